alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle multiply sequencer that shares the single EX-stage ALU between the pipeline and MULT/MULTU execution. It computes a 64-bit product by shift-add, using the shared ALU for every 32-bit addition and negation step. While it owns the ALU it stalls the pipeline, then returns the ALU to the EX stage. It sits between the EX-stage operand muxes and the ALU inputs; its HI/LO outputs feed the HI/LO registers.

## Interface
Parameters:
- none (width fixed at 32, iteration count fixed at 32)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  MULT/MULTU present in EX; sampled only in IDLE
- signed_op  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
- opa, opb  in  32  multiplicand, multiplier; sampled with start
- ex_a, ex_b  in  32  pipeline ALU operands
- ex_aluc  in  4  pipeline ALU control
- alu_a, alu_b  out  32  to shared ALU a/b
- alu_aluc  out  4  to shared ALU aluc
- alu_r  in  32  shared ALU result
- hi, lo  out  32  product, held until next accepted start
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, product valid
- stall  out  1  freeze IF/ID/EX

## Operation
- ALU encodings used: ADD = 4'b0000 (a+b), SUB = 4'b0100 (a-b).
- ALU ownership:
  - In IDLE and DONE, alu_a/alu_b/alu_aluc = ex_a/ex_b/ex_aluc, combinational pass-through.
  - In all other states the sequencer drives them.
- States: IDLE, PREA, PREB, MUL, POSTLO, POSTHI, DONE.
- IDLE, start=1: latch opa→M, opb→PL, PH=0, count=0, sa=opa[31]&signed_op, sb=opb[31]&signed_op. Go to PREA if signed_op, else MUL.
- PREA: alu_a=0, alu_b=M, aluc = sa ? SUB : ADD; M←alu_r. Go to PREB.
- PREB: same operation on PL with sb; PL←alu_r. Go to MUL.
- MUL, 32 cycles:
  - alu_a=PH, alu_b = PL[0] ? M : 0, aluc=ADD.
  - carry = (alu_r < PH), unsigned compare.
  - {PH,PL} ← {carry, alu_r, PL[31:1]}; count++.
  - At count==31, go to POSTLO if signed_op, else DONE; write hi←next PH, lo←next PL on the unsigned exit.
- POSTLO: neg=sa^sb. alu_a=0, alu_b=PL, aluc = neg ? SUB : ADD; PL←alu_r; z←(PL==0).
- POSTHI:
  - If neg: alu_a=~PH, alu_b={31'b0,z}, aluc=ADD.
  - Else: alu_a=PH, alu_b=0, aluc=ADD.
  - hi←alu_r, lo←PL. Go to DONE.
- DONE: done=1, go to IDLE unconditionally. start is ignored in DONE.
- stall = (IDLE & start) | (state ∉ {IDLE, DONE}).
- Magnitude 0x80000000 negates to itself and is correct as an unsigned magnitude.

## Timing
- Reset, asynchronous and immediate: state=IDLE, hi=lo=0, busy=done=stall=0, internal regs=0. A reset mid-operation aborts it with no partial hi/lo update.
- Cycle 0 is the IDLE cycle that accepts start.
- Unsigned: MUL in cycles 1–32, DONE in cycle 33. Latency is 33 cycles.
- Signed: PREA in cycle 1, PREB in 2, MUL in 3–34, POSTLO in 35, POSTHI in 36, DONE in 37. Latency is 37 cycles.
- Latency is fixed regardless of operand signs. Pass-through ADD keeps the cycle count constant.
- hi/lo are registered and valid from the DONE cycle. stall is low in DONE so the instruction advances.
- A start held high across DONE begins a new operation in the following IDLE cycle. The minimum gap is 1 IDLE cycle.

## Structure
- Shared package: state enum; ALU_ADD and ALU_SUB aluc constants, also used by the main control unit; MUL_ITERS=32.
- Single module. No sub-module is required. The ALU itself stays outside and is instantiated once in EX.

## Test plan
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done in cycle 33, stall high in cycles 0–32.
- Signed −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1, done in cycle 37.
- Signed 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000. Signed −1 × −1 → hi=0, lo=1.
- Pass-through:
  - Idle with ex_a=7, ex_b=9, ex_aluc=0100 → alu_a=7, alu_b=9, alu_aluc=0100, stall=0.
  - While in MUL, changes on ex_* do not reach alu_*.
- Assert rst in MUL cycle 10 → state=IDLE, busy=stall=0, hi=lo=0 immediately, before the next edge.
- start held high continuously with MULTU 6×7 → hi=0, lo=42 at cycle 33. The next operation is accepted at cycle 34 (IDLE) and completes with done at cycle 67.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the multiply sequencer and the main control unit.
package alu_mul_seq_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREA   = 3'd1,
        ST_PREB   = 3'd2,
        ST_MUL    = 3'd3,
        ST_POSTLO = 3'd4,
        ST_POSTHI = 3'd5,
        ST_DONE   = 3'd6
    } mul_state_e;

    // Shared ALU control encodings
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;

    // Shift-add iteration count
    localparam int MUL_ITERS = 32;

endpackage

// File: rtl/alu_mul_seq.sv
// Multi-cycle MULT/MULTU sequencer that borrows the EX-stage ALU for every
// add and negate step, stalling the pipeline while it owns the ALU.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic [31:0] ex_a,
    input  logic [31:0] ex_b,
    input  logic [3:0]  ex_aluc,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluc,
    input  logic [31:0] alu_r,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam logic [4:0] CNT_LAST = 5'(MUL_ITERS - 1);

    mul_state_e  state_q, state_d;
    logic [31:0] m_q, m_d;
    logic [31:0] pl_q, pl_d;
    logic [31:0] ph_q, ph_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic        sgn_q, sgn_d;
    logic        z_q, z_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        neg;
    logic        carry;

    // Product sign: negate the magnitude product when exactly one operand was negative
    assign neg = sa_q ^ sb_q;

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign stall = ((state_q == ST_IDLE) && start) ||
                   ((state_q != ST_IDLE) && (state_q != ST_DONE));

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            pl_q    <= '0;
            ph_q    <= '0;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            sgn_q   <= 1'b0;
            z_q     <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            pl_q    <= pl_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sgn_q   <= sgn_d;
            z_q     <= z_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // ALU operand ownership: pass the pipeline through in IDLE/DONE, drive it otherwise.
    // Kept apart from the next-state logic so alu_r never feeds back into alu_* here.
    always_comb begin
        alu_a    = ex_a;
        alu_b    = ex_b;
        alu_aluc = ex_aluc;
        unique case (state_q)
            ST_PREA: begin
                alu_a    = '0;
                alu_b    = m_q;
                alu_aluc = sa_q ? ALU_SUB : ALU_ADD;
            end
            ST_PREB: begin
                alu_a    = '0;
                alu_b    = pl_q;
                alu_aluc = sb_q ? ALU_SUB : ALU_ADD;
            end
            ST_MUL: begin
                alu_a    = ph_q;
                alu_b    = pl_q[0] ? m_q : '0;
                alu_aluc = ALU_ADD;
            end
            ST_POSTLO: begin
                alu_a    = '0;
                alu_b    = pl_q;
                alu_aluc = neg ? ALU_SUB : ALU_ADD;
            end
            ST_POSTHI: begin
                // High word of a 64-bit negate is ~PH plus the borrow from the low word
                alu_a    = neg ? ~ph_q : ph_q;
                alu_b    = neg ? {31'b0, z_q} : '0;
                alu_aluc = ALU_ADD;
            end
            default: begin
                alu_a    = ex_a;
                alu_b    = ex_b;
                alu_aluc = ex_aluc;
            end
        endcase
    end

    // Next-state and datapath updates from the shared ALU result
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        pl_d    = pl_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sgn_d   = sgn_q;
        z_d     = z_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        carry   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = opa;
                    pl_d    = opb;
                    ph_d    = '0;
                    cnt_d   = '0;
                    sa_d    = opa[31] & signed_op;
                    sb_d    = opb[31] & signed_op;
                    sgn_d   = signed_op;
                    state_d = signed_op ? ST_PREA : ST_MUL;
                end
            end
            ST_PREA: begin
                m_d     = alu_r;
                state_d = ST_PREB;
            end
            ST_PREB: begin
                pl_d    = alu_r;
                state_d = ST_MUL;
            end
            ST_MUL: begin
                // Wrapped sum is smaller than PH exactly when the add carried out
                carry = (alu_r < ph_q);
                ph_d  = {carry, alu_r[31:1]};
                pl_d  = {alu_r[0], pl_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) begin
                    if (sgn_q) begin
                        state_d = ST_POSTLO;
                    end else begin
                        hi_d    = {carry, alu_r[31:1]};
                        lo_d    = {alu_r[0], pl_q[31:1]};
                        state_d = ST_DONE;
                    end
                end
            end
            ST_POSTLO: begin
                pl_d    = alu_r;
                z_d     = (pl_q == 32'd0);
                state_d = ST_POSTHI;
            end
            ST_POSTHI: begin
                hi_d    = alu_r;
                lo_d    = pl_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed testbench for alu_mul_seq with a behavioural model of the shared ALU.
module tb_alu_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] opa, opb;
    logic [31:0] ex_a, ex_b;
    logic [3:0]  ex_aluc;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_aluc;
    logic [31:0] alu_r;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int total = 0;
    int bad   = 0;

    alu_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .opa       (opa),
        .opb       (opb),
        .ex_a      (ex_a),
        .ex_b      (ex_b),
        .ex_aluc   (ex_aluc),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_aluc  (alu_aluc),
        .alu_r     (alu_r),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .stall     (stall)
    );

    // Shared EX-stage ALU: SUB for 0100, ADD otherwise
    assign alu_r = (alu_aluc == 4'b0100) ? (alu_a - alu_b) : (alu_a + alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from an IDLE negedge; report the done cycle and whether
    // stall stayed high in every cycle before done and low in the done cycle.
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int done_cyc, output bit stall_ok);
        done_cyc = -1;
        stall_ok = 1'b1;
        @(negedge clk);
        start     = 1'b1;
        signed_op = s;
        opa       = a;
        opb       = b;
        #1;
        if (stall !== 1'b1) stall_ok = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (done === 1'b1) begin
                done_cyc = cyc;
                if (stall !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (stall !== 1'b1) stall_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_hilo: hi=%h lo=%h want 0/0", hi, lo);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: busy=%b done=%b stall=%b want 000", busy, done, stall);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        int  dc;
        bit  ok;
        bit  leak;
        @(negedge clk);
        ex_a = 32'd7; ex_b = 32'd9; ex_aluc = 4'b0100;
        #1;
        total++;
        if (alu_a !== 32'd7 || alu_b !== 32'd9 || alu_aluc !== 4'b0100 || stall !== 1'b0) begin
            bad++;
            $display("FAIL idle_pass: a=%h b=%h c=%b stall=%b want 7/9/0100/0",
                     alu_a, alu_b, alu_aluc, stall);
        end
        // MULTU 0x0: sequencer drives zeros with ADD throughout MUL
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; opa = 32'd0; opb = 32'd0;
        leak = 1'b0;
        dc   = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (cyc == 5) begin
                ex_a = 32'hDEAD_BEEF; ex_b = 32'h1234_5678; ex_aluc = 4'b0100;
            end
            #1;
            if (cyc >= 5 && cyc <= 32) begin
                if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_aluc !== 4'b0000) leak = 1'b1;
            end
            if (done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        total++;
        if (leak) begin
            bad++;
            $display("FAIL mul_isolation: ex_* reached alu_* during MUL (a=%h b=%h c=%b)",
                     alu_a, alu_b, alu_aluc);
        end
        total++;
        if (alu_a !== 32'hDEAD_BEEF || alu_b !== 32'h1234_5678 || alu_aluc !== 4'b0100) begin
            bad++;
            $display("FAIL done_pass: a=%h b=%h c=%b want deadbeef/12345678/0100",
                     alu_a, alu_b, alu_aluc);
        end
        total++;
        if (dc != 33 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("FAIL zero_mul: done_cyc=%0d hi=%h lo=%h want 33/0/0", dc, hi, lo);
        end
        ok = 1'b1;
        ex_a = 32'd0; ex_b = 32'd0; ex_aluc = 4'b0000;
    endtask

    task automatic test_mul(input string name, input logic s, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh,
                            input logic [31:0] el, input int lat);
        int dc;
        bit ok;
        do_op(s, a, b, dc, ok);
        total++;
        if (dc != lat) begin
            bad++;
            $display("FAIL %s_latency: done_cyc=%0d want %0d", name, dc, lat);
        end
        total++;
        if (hi !== eh || lo !== el) begin
            bad++;
            $display("FAIL %s_product: hi=%h lo=%h want %h/%h", name, hi, lo, eh, el);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_stall: stall profile wrong, want 1 in cycles 0..%0d and 0 at %0d",
                     name, lat - 1, lat);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; opa = 32'hFFFF_FFFF; opb = 32'hFFFF_FFFF;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
        end
        total++;
        if (busy !== 1'b1 || stall !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_busy: busy=%b stall=%b want 1/1", busy, stall);
        end
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_ctrl: busy=%b stall=%b done=%b want 000", busy, stall, done);
        end
        total++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("FAIL async_reset_hilo: hi=%h lo=%h want 0/0", hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        ex_a = 32'd3; ex_b = 32'd4; ex_aluc = 4'b0000;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || alu_a !== 32'd3 || alu_b !== 32'd4 || hi !== 32'd0) begin
            bad++;
            $display("FAIL post_reset_idle: busy=%b a=%h b=%h hi=%h want 0/3/4/0",
                     busy, alu_a, alu_b, hi);
        end
    endtask

    task automatic test_back_to_back();
        bit pulses_ok;
        pulses_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; opa = 32'd6; opb = 32'd7;
        for (int cyc = 1; cyc <= 67; cyc++) begin
            @(negedge clk);
            if (done !== ((cyc == 33) || (cyc == 67))) pulses_ok = 1'b0;
            if (cyc == 33) begin
                total++;
                if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd42) begin
                    bad++;
                    $display("FAIL b2b_first: done=%b hi=%h lo=%h want 1/0/2a", done, hi, lo);
                end
                opa = 32'd3; opb = 32'd5;
            end
            if (cyc == 34) begin
                total++;
                if (busy !== 1'b0 || stall !== 1'b1 || lo !== 32'd42) begin
                    bad++;
                    $display("FAIL b2b_gap: busy=%b stall=%b lo=%h want 0/1/2a", busy, stall, lo);
                end
            end
            if (cyc == 67) begin
                total++;
                if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd15) begin
                    bad++;
                    $display("FAIL b2b_second: done=%b hi=%h lo=%h want 1/0/f", done, hi, lo);
                end
                start = 1'b0;
            end
        end
        total++;
        if (!pulses_ok) begin
            bad++;
            $display("FAIL b2b_done_pulses: done not exactly at cycles 33 and 67");
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; signed_op = 1'b0;
        opa = '0; opb = '0; ex_a = '0; ex_b = '0; ex_aluc = '0;
        test_reset();
        test_passthrough();
        test_mul("umax",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
        test_mul("uhigh",   1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 33);
        test_mul("sm3x5",   1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 37);
        test_mul("smin",    1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 37);
        test_mul("sm1xm1",  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 37);
        test_mul("s7xm6",   1'b1, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 37);
        test_mul("s0xm5",   1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000, 37);
        test_mul("umultu",  1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF1, 33);
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
